// File: rtl/tinyml_quant_pkg.sv
// Shared quantisation constants and the streaming FSM state type,
// common to quantize_stream and the scale_calculator users.
package tinyml_quant_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FINISH
   } state_t;

   localparam int unsigned FRAC_BITS = 24;
   localparam int          QMAX      = 127;
   localparam int          QMIN      = -127;

endpackage

// File: rtl/quant_round_sat.sv
// Rounds a Q(FRAC_BITS) product half toward +inf and clamps it to the
// symmetric signed range [QMIN, QMAX].
module quant_round_sat
   import tinyml_quant_pkg::*;
#(
   parameter int unsigned FRAC_BITS = 24,
   parameter int unsigned OUT_W     = 8
) (
   input  logic [63:0]      product,
   output logic [OUT_W-1:0] result
);

   // One guard bit so adding the half-LSB can never overflow.
   localparam logic signed [64:0] HALF = 65'sd1 <<< (FRAC_BITS - 1);
   localparam logic signed [64:0] HI   = 65'(QMAX);
   localparam logic signed [64:0] LO   = 65'(QMIN);

   logic signed [64:0] sum;
   logic signed [64:0] r;

   always_comb begin
      sum = $signed({product[63], product}) + HALF;
      r   = sum >>> FRAC_BITS;
      if (r > HI) begin
         result = OUT_W'(QMAX);
      end else if (r < LO) begin
         result = OUT_W'(QMIN);
      end else begin
         result = r[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/quantize_stream.sv
// Streams a vector of signed elements through scale-multiply, round and
// saturate, with a two-stage valid/ready pipeline and a done pulse.
module quantize_stream
   import tinyml_quant_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned OUT_W     = 8,
   parameter int unsigned FRAC_BITS = 24,
   parameter int unsigned LEN_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [31:0]       reciprocal_scale,
   input  logic [LEN_W-1:0]  vec_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   state_t state;
   state_t state_next;

   logic [31:0]      scale_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] in_cnt;
   logic [LEN_W-1:0] out_cnt;

   logic             s1_valid;
   logic [63:0]      s1_prod;
   logic             s2_valid;
   logic [OUT_W-1:0] s2_data;

   logic [63:0]      prod;
   logic [OUT_W-1:0] rounded;
   logic             s1_adv;
   logic             s2_adv;
   logic             in_fire;
   logic             out_fire;

   always_comb begin
      s2_adv   = !s2_valid || out_ready;
      s1_adv   = !s1_valid || s2_adv;
      out_fire = s2_valid && out_ready;
      in_fire  = in_valid && in_ready;
      prod     = {{(64-DATA_W){in_data[DATA_W-1]}}, in_data} * {32'b0, scale_q};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = (vec_len != '0) ? RUN : FINISH;
            end
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = (in_cnt < len_q) && s1_adv;
            if (in_valid && in_ready && (in_cnt == len_q - LEN_W'(1))) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (out_fire && (out_cnt == len_q - LEN_W'(1))) begin
               state_next = FINISH;
            end
         end
         FINISH: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scale_q  <= '0;
         len_q    <= '0;
         in_cnt   <= '0;
         out_cnt  <= '0;
         s1_valid <= 1'b0;
         s1_prod  <= '0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else begin
         if (state == IDLE && start) begin
            scale_q <= reciprocal_scale;
            len_q   <= vec_len;
            in_cnt  <= '0;
            out_cnt <= '0;
         end else begin
            if (in_fire) in_cnt <= in_cnt + LEN_W'(1);
            if (out_fire) out_cnt <= out_cnt + LEN_W'(1);
         end
         // Each stage loads only when its successor frees up, so a held
         // S2 element is never overwritten under back-pressure.
         if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) s1_prod <= prod;
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= rounded;
         end
      end
   end

   quant_round_sat #(
      .FRAC_BITS(FRAC_BITS),
      .OUT_W    (OUT_W)
   ) u_round_sat (
      .product(s1_prod),
      .result (rounded)
   );

   assign out_valid = s2_valid;
   assign out_data  = s2_data;

endmodule

// File: doc/quantize_stream.md
QUANTIZE_STREAM -- requirements
Module: quantize_stream

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 32, signed input element width; OUT_W, 8, signed output width; FRAC_BITS, 24, fractional bits of reciprocal_scale; LEN_W, 16, vector-length counter width.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  begin one vector; sampled only in IDLE.
REQ-005 reciprocal_scale  input  32  unsigned Q8.24 scale from scale_calculator; sampled with start.
REQ-006 vec_len  input  LEN_W  number of elements in the vector; sampled with start.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_data  input  DATA_W  signed element.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_data  output  OUT_W  signed quantized element.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 busy  output  1  high from the cycle after an accepted start until done.
REQ-014 done  output  1  one-cycle pulse after the last element leaves.

Function
REQ-015 Transfers SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output); out_data SHALL hold stable while out_valid&&!out_ready.
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, FINISH; IDLE->RUN on start with vec_len!=0; IDLE->FINISH on start with vec_len==0; RUN->DRAIN when the vec_len-th input is accepted; DRAIN->FINISH when the last output transfers; FINISH->IDLE unconditionally after one cycle, with done=1 for that cycle only.
REQ-017 start SHALL be ignored outside IDLE; reciprocal_scale and vec_len SHALL be latched at start and held for the whole vector.
REQ-018 in_ready SHALL be 1 only in RUN with input count < vec_len and stage 1 able to advance (stage 1 empty, or stage 2 empty or transferring).
REQ-019 Pipeline SHALL be two registered stages: S1 = signed 64-bit product of in_data and the zero-extended latched scale; S2 = rounded and saturated result driving out_data/out_valid.
REQ-020 Latency SHALL be 2 cycles from input transfer to out_valid without back-pressure; throughput SHALL be 1 element/cycle when out_ready=1.
REQ-021 Rounding SHALL be r = (product + 2^(FRAC_BITS-1)) arithmetically shifted right by FRAC_BITS (round half toward +inf), computed without overflow at full width.
REQ-022 Saturation SHALL clamp r to [-127, +127] (symmetric; -128 never produced).
REQ-023 Back-pressure SHALL stall both stages without loss or duplication; an element held in S2 SHALL not be overwritten.
REQ-024 reciprocal_scale==0 SHALL yield out_data=0 for every element.
REQ-025 Input and output counters SHALL each count to exactly vec_len; the maximum vec_len (2^LEN_W-1) SHALL not wrap.
REQ-026 Input transfers are never accepted after vec_len elements; extra in_valid SHALL be ignored.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, clear counters, latched scale/length and both stage valid bits.
REQ-028 Reset mid-vector SHALL discard all in-flight elements; no done pulse SHALL follow.

Structure
REQ-029 Package tinyml_quant_pkg SHALL hold the FSM state enum, FRAC_BITS, QMAX=127, QMIN=-127, shared with scale_calculator users.
REQ-030 One combinational sub-module quant_round_sat (64-bit product in, OUT_W result out) SHALL implement REQ-021/022.

Verification
REQ-031 scale=2130706 (max_abs 1000), vec_len=3, inputs 1000, -1000, 0 -> outputs 127, -127, 0; done 1 cycle after the third output transfers.
REQ-032 Same scale, inputs 500, 2000, -2000 -> 63, 127 (sat), -127 (sat).
REQ-033 vec_len=8, out_ready toggled 1010... with continuous in_valid -> 8 outputs in order, none lost/duplicated, in_ready low while S1 and S2 are both full and out_ready=0.
REQ-034 start with vec_len=0 -> no in_ready, no out_valid, done pulse the cycle after start, back to IDLE.
REQ-035 reset_n pulsed low after 2 of 5 elements -> out_valid and busy drop immediately, no done; a fresh start then runs correctly.
REQ-036 scale=0, vec_len=4, arbitrary inputs -> four outputs of 0; start re-asserted during RUN -> ignored.
